// File: rtl/regfile_scb.sv
// Register file with a per-register busy scoreboard and an NREGS-1 cycle zeroing sweep.
// Optional `REGFILE_BYPASS_EN forwards an IDLE writeback to matching read ports combinationally.

module regfile_scb_rport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] mem,
  input  logic [NREGS-1:0]           busy,
  input  logic [AW-1:0]              raddr,
  input  logic                       byp_vld,
  input  logic [AW-1:0]              waddr,
  input  logic [XLEN-1:0]            wdata,
  output logic [XLEN-1:0]            rdata,
  output logic                       rbusy
);
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (raddr != '0) begin
      if (byp_vld && waddr == raddr) begin
        rdata = wdata;
        rbusy = 1'b0;
      end else begin
        rdata = mem[raddr];
        rbusy = busy[raddr];
      end
    end
  end
endmodule

module regfile_scb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                wr_en,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                clr_req,
  output logic                ready
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]                 state;
  logic [AW-1:0]              idx;
  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           busy;
  logic                       idle;
  logic                       wr_ok;
  logic                       iss_ok;
  logic                       byp_vld;

  assign idle   = (state == ST_IDLE);
  assign ready  = idle;
  assign wr_ok  = idle && wr_en && (waddr != '0);
  assign iss_ok = idle && iss_en && (iss_rd != '0);

`ifdef REGFILE_BYPASS_EN
  assign byp_vld = wr_ok;
`else
  assign byp_vld = 1'b0;
`endif

  // Control and scoreboard; data array below carries no reset, the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      idx   <= AW'(1);
      busy  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_ok)  busy[waddr]  <= 1'b0;
          // Issue is applied last so it wins over a same-edge writeback.
          if (iss_ok) busy[iss_rd] <= 1'b1;
          if (clr_req) begin
            state <= ST_CLEAR;
            idx   <= AW'(1);
          end
        end
        ST_CLEAR: begin
          busy[idx] <= 1'b0;
          idx       <= idx + AW'(1);
          if (idx == AW'(NREGS-1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) mem[idx]   <= '0;
      else if (wr_ok)        mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_scb_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rport (
      .mem    (mem),
      .busy   (busy),
      .raddr  (raddr[i*AW +: AW]),
      .byp_vld(byp_vld),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[i*XLEN +: XLEN]),
      .rbusy  (rbusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_scb.sv
// Randomized scoreboard bench for regfile_scb against an abstract register/busy model.
module tb_regfile_scb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wr_en;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                clr_req;
  logic                ready;

  regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
    .iss_rd(iss_rd), .clr_req(clr_req), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              kind;  // 0 ready, 1 rdata, 2 rbusy
    int              port;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: register values, whether each value is known, busy flags,
  // and how far a zeroing sweep has progressed.
  logic [XLEN-1:0] m_mem   [NREGS];
  bit              m_known [NREGS];
  bit              m_busy  [NREGS];
  bit              m_valid = 0;
  bit              m_clear = 0;
  int              m_swept = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [XLEN-1:0] act;
      string nm;
      e = q.pop_front();
      case (e.kind)
        0:       begin act = XLEN'(ready);                 nm = "ready"; end
        1:       begin act = rdata[e.port*XLEN +: XLEN];   nm = "rdata"; end
        default: begin act = XLEN'(rbusy[e.port]);         nm = "rbusy"; end
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s port%0d raddr=%0d t=%0t: got %h expected %h",
                 nm, e.port, raddr[e.port*AW +: AW], $time, act, e.exp);
      end
    end
  end

  task automatic step();
    exp_t e;
    if (m_valid) begin
      e.kind = 0; e.port = 0; e.exp = XLEN'(!m_clear);
      q.push_back(e);
      for (int i = 0; i < NRD; i++) begin
        int a;
        bit byp;
        a   = int'(raddr[i*AW +: AW]);
        byp = 0;
`ifdef REGFILE_BYPASS_EN
        byp = !m_clear && wr_en && (waddr != 0) && (int'(waddr) == a);
`endif
        e.port = i;
        e.kind = 2;
        e.exp  = (a == 0 || byp) ? '0 : XLEN'(m_busy[a]);
        q.push_back(e);
        e.kind = 1;
        if (a == 0) begin
          e.exp = '0; q.push_back(e);
        end else if (byp) begin
          e.exp = wdata; q.push_back(e);
        end else if (m_known[a]) begin
          e.exp = m_mem[a]; q.push_back(e);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1;
      m_clear = 1;
      m_swept = 0;
      foreach (m_busy[k]) m_busy[k] = 0;
    end else if (m_valid && m_clear) begin
      // Sweep zeroes registers 1..NREGS-1 in order, one per cycle.
      m_mem[m_swept+1]   = '0;
      m_known[m_swept+1] = 1;
      m_busy[m_swept+1]  = 0;
      m_swept++;
      if (m_swept == NREGS-1) m_clear = 0;
    end else if (m_valid) begin
      if (wr_en && waddr != 0) begin
        m_mem[waddr] = wdata; m_known[waddr] = 1; m_busy[waddr] = 0;
      end
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1;
      if (clr_req) begin m_clear = 1; m_swept = 0; end
    end
    #1;
  endtask

  task automatic quiet();
    wr_en = 0; iss_en = 0; clr_req = 0;
  endtask

  task automatic rand_in(input bit allow_clr);
    wr_en   = ($urandom % 2) == 0;
    waddr   = AW'($urandom);
    wdata   = $urandom;
    iss_en  = ($urandom % 3) == 0;
    iss_rd  = ($urandom % 4 == 0) ? waddr : AW'($urandom);
    raddr   = NRD*AW'($urandom);
    if ($urandom % 3 == 0) raddr[AW-1:0] = waddr;
    clr_req = allow_clr && ($urandom % 60 == 0);
  endtask

  task automatic read_all();
    quiet();
    for (int r = 0; r < NREGS; r += NRD) begin
      for (int i = 0; i < NRD; i++) raddr[i*AW +: AW] = AW'(r + i);
      step();
    end
  endtask

  task automatic wait_idle();
    quiet();
    for (int n = 0; n < 2*NREGS && m_clear; n++) step();
    n_chk++;
    if (m_clear || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_idle expired t=%0t: ready=%b model_clear=%0d", $time, ready, m_clear);
    end
  endtask

  initial begin
    rst = 1; raddr = '0; waddr = '0; wdata = '0; iss_rd = '0;
    quiet();
    step();
    n_chk++;
    if (ready !== 1'b0 || rbusy !== '0) begin
      n_fail++;
      $display("FAIL reset state t=%0t: ready=%b rbusy=%b expected 0/0", $time, ready, rbusy);
    end
    rst = 0;
    // Inputs during the reset sweep are all ignored.
    for (int n = 0; n < NREGS-1; n++) begin rand_in(1); step(); end
    read_all();

    waddr = 5; wdata = 32'hDEADBEEF; wr_en = 1; step();
    wr_en = 0; raddr = {AW'(5), AW'(5)}; step();
    waddr = 0; wdata = 32'h1234; wr_en = 1; raddr = '0; step();
    wr_en = 0; step();

    iss_rd = 7; iss_en = 1; step();
    iss_en = 0; raddr = {AW'(7), AW'(7)}; step();
    waddr = 7; wdata = 32'h55; wr_en = 1; step();
    wr_en = 0; step();

    iss_rd = 9; iss_en = 1; waddr = 9; wdata = 32'h99; wr_en = 1;
    raddr = {AW'(9), AW'(9)}; step();
    quiet(); step();

    raddr = {AW'(0), AW'(3)}; waddr = 3; wdata = 32'hA5A5; wr_en = 1; step();
    wr_en = 0; step();

    for (int n = 0; n < 400; n++) begin rand_in(1); step(); end

    wait_idle();
    for (int r = 1; r < NREGS; r++) begin
      wr_en = 1; waddr = AW'(r); wdata = $urandom;
      iss_en = 1; iss_rd = AW'(r); raddr = {AW'(r), AW'(r)};
      step();
    end
    quiet(); clr_req = 1; step();
    for (int n = 0; n < NREGS-1; n++) begin
      rand_in(0); clr_req = ($urandom % 2) == 0; step();
    end
    read_all();

    clr_req = 1; step();
    for (int n = 0; n < 9; n++) begin rand_in(1); step(); end
    quiet(); rst = 1; step();
    rst = 0;
    for (int n = 0; n < NREGS-1; n++) begin rand_in(1); step(); end
    read_all();

    for (int n = 0; n < 200; n++) begin rand_in(1); step(); end
    read_all();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
